code_pair_fetcher: RTL and testbench
====================================

// Module: code_pair_fetcher
// PURPOSE
// - Upstream feeder for the decompress stage in the DCNN IO path.
// - Takes a compressed byte stream (valid/ready), unpacks it LSB-first into 3-bit codes, and presents them in pairs on in1/in2.
// - Holds each pair under work until decompress raises done, then advances. Counts the pairs issued and flags end of stream.
// PARAMETERS
// - IN_W    8   input byte width
// - CODE_W  3   width of one code; one pair is 2*CODE_W = 6 bits
// - BUF_W   16  bit-buffer capacity; must be >= IN_W + 2*CODE_W - 1
// PORTS
// - clk        in   1      single clock, rising edge
// - rst        in   1      synchronous, active-high reset
// - start      in   1      pulse in IDLE: begin a stream, clear pairCount
// - inData     in   IN_W   compressed byte; bit 0 is consumed first
// - inValid    in   1      inData is valid
// - inLast     in   1      qualifies inData as the final byte of the stream
// - inReady    out  1      byte accepted on the cycle where inValid && inReady
// - in1        out  CODE_W first code of the pair = buf[2:0], to decompress.in1
// - in2        out  CODE_W second code of the pair = buf[5:3], to decompress.in2
// - work       out  1      a pair is presented, to decompress.work
// - done       in   1      from decompress; pair is consumed on work && done
// - pairCount  out  32     number of pairs consumed in the current stream
// - streamDone out  1      one-cycle pulse after the last full pair is consumed
// BEHAVIOUR
// - Reset values: state=IDLE, buf=0, cnt=0, lastSeen=0, pairCount=0.
//   Outputs after reset: inReady=0, work=0, in1=in2=0, streamDone=0.
// - Reset mid-stream: takes effect at the next edge. Partial bits and the pending pair are dropped. No handshake completes in that cycle.
// - States: IDLE -> RUN on start. RUN -> FIN when lastSeen && cnt<6 && !work. FIN -> IDLE unconditionally (one cycle).
// - start outside IDLE is ignored.
// - inReady = (state==RUN) && !lastSeen && (cnt <= BUF_W-IN_W). It is computed from the current cnt and is conservative on consume cycles.
// - Accept: inData is appended at bit position cnt (after any same-cycle shift), cnt += IN_W. lastSeen <= inLast.
// - work = (state==RUN) && (cnt >= 6). in1, in2 and work come from flops only; there is no comb path from done/inValid to them.
// - Stall: while work && !done, in1, in2 and work hold stable. Input bytes may still be accepted if there is room.
// - Consume (work && done): buf shifts right by 6, cnt -= 6, pairCount += 1.
// - Simultaneous accept and consume in one cycle:
//   buf_next = (buf >> 6) | (inData << (cnt-6)), cnt_next = cnt - 6 + IN_W.
// - Leftover bits: at end of stream, leftover bits (cnt < 6) are discarded, not padded.
// - streamDone is high for exactly the FIN cycle. In FIN, cnt and buf clear; pairCount holds until the next start.
// - Latency: a byte accepted at edge t can raise work at t+1. Peak throughput is one pair per cycle while done is held high.
// - pairCount wraps modulo 2^32. The empty-stream case (start then a single inLast byte) is legal.
// STRUCTURE
// - Shared package dcnn_io_pkg: CODE_W, IN_W, PAIR_W = 2*CODE_W, and the state enum {IDLE, RUN, FIN}.
// - One sub-module, code_bit_buffer: owns buf and cnt plus the append/shift/count arithmetic. Its inputs are push, pop and data; its outputs are buf and cnt.
// - The top level holds the FSM, the handshake logic and pairCount.
// TESTING
// - Ordered pairs: start, then bytes 0xD1, 0x58, 0x1F (inLast on 0x1F), done tied to 1.
//   Expect pairs (1,2), (3,4), (5,6), (7,0) in order, then streamDone, and pairCount=4.
// - Stall: same stream, done held low for 5 cycles on pair 2.
//   Expect in1=3, in2=4 and work stable throughout, inReady=0 whenever cnt>8, and no pair lost or duplicated.
// - Discard: single byte 0xFF with inLast.
//   Expect exactly one pair (7,7), the 2 leftover bits dropped, streamDone one cycle later, pairCount=1.
// - Overlap: 6 random bytes with inValid held high and done=1.
//   Output must match a reference LSB-first unpack model, covering cycles with a simultaneous accept and consume. Expect pairCount=8.
// - Reset mid-stream: rst after 2 bytes.
//   Next cycle: work=0, inReady=0, pairCount=0, state IDLE. A fresh start and stream then behaves as in the ordered-pairs scenario.
// - start pulsed during RUN: ignored. pairCount is not cleared and the pair sequence is unchanged.

Source files
------------

// File: rtl/dcnn_io_pkg.sv
// ----------------------------------------------------------------------------
// dcnn_io_pkg
// Shared constants and types for the DCNN IO path blocks.
//   IN_W    : width of one compressed input byte
//   CODE_W  : width of one unpacked code
//   PAIR_W  : width of a code pair handed to decompress (two codes)
//   BUF_W   : bit-buffer capacity of the pair fetcher
//   state_t : fetcher control states
// ----------------------------------------------------------------------------
package dcnn_io_pkg;

    localparam int IN_W   = 8;
    localparam int CODE_W = 3;
    localparam int PAIR_W = 2 * CODE_W;
    // Must hold a full pair's worth of leftovers plus one fresh byte:
    // BUF_W >= IN_W + PAIR_W - 1.
    localparam int BUF_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/code_pair_fetcher_if.sv
// ----------------------------------------------------------------------------
// code_pair_fetcher_if
// Bundles the two handshakes of the pair fetcher:
//   byte stream in : inData, inValid, inLast, inReady (valid/ready)
//   pair out       : in1, in2, work, done (work/done hold-until-done)
// Modports:
//   master : the environment (byte producer + decompress stage)
//   slave  : the code_pair_fetcher itself
// ----------------------------------------------------------------------------
interface code_pair_fetcher_if
    import dcnn_io_pkg::*;
#(
    parameter int IN_W   = dcnn_io_pkg::IN_W,
    parameter int CODE_W = dcnn_io_pkg::CODE_W
);

    logic [IN_W-1:0]   inData;
    logic              inValid;
    logic              inLast;
    logic              inReady;
    logic [CODE_W-1:0] in1;
    logic [CODE_W-1:0] in2;
    logic              work;
    logic              done;

    modport master (
        output inData, inValid, inLast, done,
        input  inReady, in1, in2, work
    );

    modport slave (
        input  inData, inValid, inLast, done,
        output inReady, in1, in2, work
    );

endinterface

// File: rtl/code_bit_buffer.sv
// ----------------------------------------------------------------------------
// code_bit_buffer
// LSB-first bit accumulator. Bits at [cnt-1:0] are valid, everything above
// is kept at zero so appends can simply OR new data in.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear (end of stream), same effect as rst
//   push     : append data at bit position cnt (after any same-cycle pop)
//   pop      : drop the lowest POP_W bits (caller guarantees cnt >= POP_W)
//   data     : bits to append, bit 0 lands first
//   bits     : buffer contents
//   cnt      : number of valid bits in the buffer
// ----------------------------------------------------------------------------
module code_bit_buffer
    import dcnn_io_pkg::*;
#(
    parameter int IN_W  = dcnn_io_pkg::IN_W,
    parameter int POP_W = dcnn_io_pkg::PAIR_W,
    parameter int BUF_W = dcnn_io_pkg::BUF_W,
    localparam int CNT_W = $clog2(BUF_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [IN_W-1:0]  data,
    output logic [BUF_W-1:0] bits,
    output logic [CNT_W-1:0] cnt
);

    logic [BUF_W-1:0] shifted;
    logic [CNT_W-1:0] base;
    logic [BUF_W-1:0] bits_next;
    logic [CNT_W-1:0] cnt_next;

    // Pop is applied first, then the append lands right after the bits that
    // survive the pop. This is what lets accept and consume share a cycle.
    always_comb begin
        shifted   = bits;
        base      = cnt;
        if (pop) begin
            shifted = bits >> POP_W;
            base    = cnt - CNT_W'(POP_W);
        end
        bits_next = shifted;
        cnt_next  = base;
        if (push) begin
            bits_next = shifted | (BUF_W'(data) << base);
            cnt_next  = base + CNT_W'(IN_W);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            bits <= '0;
            cnt  <= '0;
        end else begin
            bits <= bits_next;
            cnt  <= cnt_next;
        end
    end

endmodule

// File: rtl/code_pair_fetcher.sv
// ----------------------------------------------------------------------------
// code_pair_fetcher
// Upstream feeder for the decompress stage. Unpacks a compressed byte stream
// LSB-first into CODE_W-bit codes and presents them two at a time.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : pulse in IDLE to open a stream and clear pairCount
//   bus        : slave side of code_pair_fetcher_if
//                 inData/inValid/inLast/inReady - byte stream in
//                 in1/in2/work/done             - pair handed to decompress
//   pairCount  : pairs consumed in the current stream (wraps at 2^32)
//   streamDone : one-cycle pulse after the last full pair is consumed
// ----------------------------------------------------------------------------
module code_pair_fetcher
    import dcnn_io_pkg::*;
#(
    parameter int IN_W   = dcnn_io_pkg::IN_W,
    parameter int CODE_W = dcnn_io_pkg::CODE_W,
    parameter int BUF_W  = dcnn_io_pkg::BUF_W,
    localparam int PAIR_W = 2 * CODE_W,
    localparam int CNT_W  = $clog2(BUF_W + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    code_pair_fetcher_if.slave   bus,
    output logic [31:0]          pairCount,
    output logic                 streamDone
);

    state_t           state;
    state_t           state_next;
    logic             last_seen;
    logic [BUF_W-1:0] bits;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             consume;
    logic             begin_stream;

    // ------------------------------------------------------------------
    // Bit buffer
    // ------------------------------------------------------------------
    code_bit_buffer #(
        .IN_W  (IN_W),
        .POP_W (PAIR_W),
        .BUF_W (BUF_W)
    ) u_buf (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == FIN),
        .push (accept),
        .pop  (consume),
        .data (bus.inData),
        .bits (bits),
        .cnt  (cnt)
    );

    // Only the low pair of the buffer is ever presented; the upper bits are
    // staging for future pairs.
    logic unused_hi;
    assign unused_hi = ^bits[BUF_W-1:PAIR_W];

    // ------------------------------------------------------------------
    // Handshakes. All outputs depend on flops only, so there is no
    // combinational path from done/inValid back to work/in1/in2/inReady.
    // inReady uses the pre-consume cnt: a byte that would only fit after
    // this cycle's pop waits one cycle.
    // ------------------------------------------------------------------
    assign bus.inReady = (state == RUN) && !last_seen &&
                         (cnt <= CNT_W'(BUF_W - IN_W));
    assign bus.work    = (state == RUN) && (cnt >= CNT_W'(PAIR_W));
    assign bus.in1     = bits[CODE_W-1:0];
    assign bus.in2     = bits[PAIR_W-1:CODE_W];
    assign streamDone  = (state == FIN);

    assign accept       = bus.inValid && bus.inReady;
    assign consume      = bus.work && bus.done;
    assign begin_stream = (state == IDLE) && start;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // RUN ends once the last byte is in and fewer than a pair's worth of
    // bits remain; those leftovers are dropped by the FIN clear.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN:  if (last_seen && (cnt < CNT_W'(PAIR_W)) && !bus.work)
                      state_next = FIN;
            FIN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Stream bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            last_seen <= 1'b0;
        end else if (begin_stream || (state == FIN)) begin
            last_seen <= 1'b0;
        end else if (accept) begin
            last_seen <= bus.inLast;
        end
    end

    // Held through FIN and IDLE so the final count stays readable until the
    // next stream opens.
    always_ff @(posedge clk) begin
        if (rst) begin
            pairCount <= '0;
        end else if (begin_stream) begin
            pairCount <= '0;
        end else if (consume) begin
            pairCount <= pairCount + 32'd1;
        end
    end

endmodule

// File: tb/tb_code_pair_fetcher.sv
module tb_code_pair_fetcher;

    typedef logic [7:0] byte_q_t[$];
    typedef logic [5:0] pair_q_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] pairCount;
    logic        streamDone;

    int checks   = 0;
    int failures = 0;

    pair_q_t exp_q;
    pair_q_t got_q;
    int      sd_seen;
    int      both_cnt;
    int      stall_cyc;

    code_pair_fetcher_if bus();

    code_pair_fetcher dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus),
        .pairCount  (pairCount),
        .streamDone (streamDone)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] pk(input int c1, input int c2);
        logic [2:0] a;
        logic [2:0] b;
        a = 3'(c1);
        b = 3'(c2);
        return {b, a};
    endfunction

    // Reference: flatten the bytes into one LSB-first bit list, then cut it
    // into 6-bit pairs; a trailing partial pair is simply not emitted.
    function automatic void build_expected(input byte_q_t bytes);
        bit         bl[$];
        logic [5:0] v;
        exp_q.delete();
        foreach (bytes[i]) begin
            for (int j = 0; j < 8; j++) bl.push_back(bytes[i][j]);
        end
        for (int k = 0; k + 6 <= bl.size(); k += 6) begin
            for (int j = 0; j < 6; j++) v[j] = bl[k+j];
            exp_q.push_back(v);
        end
    endfunction

    // Drives one stream and checks the cycle-level protocol against a count
    // based model: bits held = 8*accepted - 6*consumed.
    task automatic run_stream(input byte_q_t bytes, input int stall_pair,
                              input int stall_len, input bit rand_io,
                              input int start_at, input int abort_after,
                              input string tag);
        int   idx = 0, npop = 0, mcnt = 0, cyc = 0, stall_left;
        bit   mrun, mlast, mfin, work_e, rdy_e, push, pop, d, v;
        bit   prev_stall = 0;
        logic [2:0] p1 = 0, p2 = 0;
        stall_left = stall_len;
        build_expected(bytes);
        got_q.delete();
        sd_seen = 0; both_cnt = 0; stall_cyc = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mrun = 1; mlast = 0; mfin = 0;
        forever begin
            work_e = mrun && (mcnt >= 6);
            rdy_e  = mrun && !mlast && (mcnt <= 8);
            checks++;
            if (bus.work !== work_e) begin
                failures++;
                $display("FAIL %s work cyc=%0d: got %b want %b", tag, cyc, bus.work, work_e);
            end
            checks++;
            if (bus.inReady !== rdy_e) begin
                failures++;
                $display("FAIL %s inReady cyc=%0d: got %b want %b", tag, cyc, bus.inReady, rdy_e);
            end
            checks++;
            if (streamDone !== mfin) begin
                failures++;
                $display("FAIL %s streamDone cyc=%0d: got %b want %b", tag, cyc, streamDone, mfin);
            end
            checks++;
            if (pairCount !== 32'(npop)) begin
                failures++;
                $display("FAIL %s pairCount cyc=%0d: got %0d want %0d", tag, cyc, pairCount, npop);
            end
            if (streamDone === 1'b1) sd_seen++;
            if (work_e) begin
                checks++;
                if (npop >= exp_q.size()) begin
                    failures++;
                    $display("FAIL %s extra pair %0d: got work, want none", tag, npop);
                end else if ({bus.in2, bus.in1} !== exp_q[npop]) begin
                    failures++;
                    $display("FAIL %s pair %0d: got (%0d,%0d) want (%0d,%0d)", tag, npop,
                             bus.in1, bus.in2, exp_q[npop][2:0], exp_q[npop][5:3]);
                end
            end
            if (prev_stall) begin
                checks++;
                if (bus.work !== 1'b1 || bus.in1 !== p1 || bus.in2 !== p2) begin
                    failures++;
                    $display("FAIL %s stall hold: got w=%b (%0d,%0d) want w=1 (%0d,%0d)",
                             tag, bus.work, bus.in1, bus.in2, p1, p2);
                end
            end
            if (mfin) begin
                bus.inValid = 1'b0; bus.inLast = 1'b0; bus.done = 1'b0; start = 1'b0;
                @(posedge clk); #1;
                break;
            end
            if (abort_after > 0 && idx >= abort_after) begin
                // done high on purpose: the reset must swallow the consume.
                rst = 1'b1; bus.done = 1'b1; bus.inValid = 1'b1; start = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0; bus.done = 1'b0; bus.inValid = 1'b0;
                return;
            end
            cyc++;
            if (cyc > 400) begin
                failures++;
                $display("FAIL %s timeout: got no streamDone want streamDone within 400 cycles", tag);
                rst = 1'b1; bus.inValid = 1'b0; bus.done = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            d = 1'b1;
            if (npop == stall_pair && stall_left > 0 && work_e) begin
                d = 1'b0; stall_left--; stall_cyc++;
            end else if (rand_io) begin
                d = ($urandom_range(0, 2) != 0);
            end
            v = (idx < bytes.size()) && (!rand_io || $urandom_range(0, 3) != 0);
            bus.done    = d;
            start       = (cyc == start_at);
            bus.inValid = v;
            bus.inData  = v ? bytes[idx] : 8'($urandom);
            bus.inLast  = v && (idx == bytes.size() - 1);
            push = v && rdy_e;
            pop  = d && work_e;
            prev_stall = work_e && !d;
            p1 = bus.in1; p2 = bus.in2;
            if (pop) begin
                got_q.push_back({bus.in2, bus.in1});
                npop++;
            end
            if (push && pop) both_cnt++;
            if (mrun && mlast && mcnt < 6) begin
                mrun = 0; mfin = 1;
            end else begin
                mcnt = mcnt - (pop ? 6 : 0) + (push ? 8 : 0);
                if (push) begin
                    mlast = bus.inLast;
                    idx++;
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (streamDone !== 1'b0 || pairCount !== 32'(npop)) begin
            failures++;
            $display("FAIL %s after FIN: got sd=%b cnt=%0d want sd=0 cnt=%0d",
                     tag, streamDone, pairCount, npop);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        bus.inValid = 1'b0; bus.inLast = 1'b0; bus.inData = '0; bus.done = 1'b0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        checks++;
        if (bus.inReady !== 1'b0 || bus.work !== 1'b0 || streamDone !== 1'b0) begin
            failures++;
            $display("FAIL reset ctl: got rdy=%b work=%b sd=%b want 0 0 0",
                     bus.inReady, bus.work, streamDone);
        end
        checks++;
        if (bus.in1 !== 3'd0 || bus.in2 !== 3'd0 || pairCount !== 32'd0) begin
            failures++;
            $display("FAIL reset data: got in1=%0d in2=%0d cnt=%0d want 0 0 0",
                     bus.in1, bus.in2, pairCount);
        end
        // With no start the block must sit idle, even with traffic offered.
        bus.inValid = 1'b1; bus.inData = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.inReady !== 1'b0 || bus.work !== 1'b0) begin
            failures++;
            $display("FAIL reset idle: got rdy=%b work=%b want 0 0", bus.inReady, bus.work);
        end
        bus.inValid = 1'b0;
    endtask

    task automatic check_ordered(input string tag);
        pair_q_t tbl;
        tbl = '{pk(1, 2), pk(3, 4), pk(5, 6), pk(7, 0)};
        checks++;
        if (got_q.size() != 4) begin
            failures++;
            $display("FAIL %s pair total: got %0d want 4", tag, got_q.size());
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== tbl[i]) begin
                failures++;
                $display("FAIL %s seq %0d: got (%0d,%0d) want (%0d,%0d)", tag, i,
                         got_q[i][2:0], got_q[i][5:3], tbl[i][2:0], tbl[i][5:3]);
            end
        end
        checks++;
        if (pairCount !== 32'd4 || sd_seen != 1) begin
            failures++;
            $display("FAIL %s end: got cnt=%0d sd=%0d want cnt=4 sd=1", tag, pairCount, sd_seen);
        end
    endtask

    task automatic test_ordered();
        run_stream('{8'hD1, 8'h58, 8'h1F}, -1, 0, 1'b0, 0, 0, "ordered");
        check_ordered("ordered");
    endtask

    task automatic test_stall();
        run_stream('{8'hD1, 8'h58, 8'h1F}, 1, 5, 1'b0, 0, 0, "stall");
        check_ordered("stall");
        checks++;
        if (stall_cyc != 5) begin
            failures++;
            $display("FAIL stall length: got %0d want 5", stall_cyc);
        end
    endtask

    task automatic test_discard();
        run_stream('{8'hFF}, -1, 0, 1'b0, 0, 0, "discard");
        checks++;
        if (got_q.size() != 1 || got_q[0] !== pk(7, 7)) begin
            failures++;
            $display("FAIL discard pairs: got n=%0d want one (7,7)", got_q.size());
        end
        checks++;
        if (pairCount !== 32'd1 || sd_seen != 1) begin
            failures++;
            $display("FAIL discard end: got cnt=%0d sd=%0d want 1 1", pairCount, sd_seen);
        end
    endtask

    task automatic compare_model(input string tag);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s pair total: got %0d want %0d", tag, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL %s seq %0d: got %h want %h", tag, i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_overlap();
        byte_q_t b;
        for (int i = 0; i < 6; i++) b.push_back(8'($urandom));
        run_stream(b, -1, 0, 1'b0, 0, 0, "overlap");
        compare_model("overlap");
        checks++;
        if (pairCount !== 32'd8) begin
            failures++;
            $display("FAIL overlap count: got %0d want 8", pairCount);
        end
        checks++;
        if (both_cnt == 0) begin
            failures++;
            $display("FAIL overlap coverage: got 0 accept+consume cycles want >0");
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            byte_q_t b;
            int n;
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) b.push_back(8'($urandom));
            run_stream(b, -1, 0, 1'b1, 0, 0, "random");
            compare_model("random");
            checks++;
            if (pairCount !== 32'((8 * n) / 6)) begin
                failures++;
                $display("FAIL random count: got %0d want %0d", pairCount, (8 * n) / 6);
            end
        end
    endtask

    task automatic test_reset_mid();
        run_stream('{8'hD1, 8'h58, 8'h1F}, -1, 0, 1'b0, 0, 2, "rstmid");
        checks++;
        if (bus.work !== 1'b0 || bus.inReady !== 1'b0 || pairCount !== 32'd0 ||
            streamDone !== 1'b0) begin
            failures++;
            $display("FAIL rstmid after: got w=%b rdy=%b cnt=%0d sd=%b want 0 0 0 0",
                     bus.work, bus.inReady, pairCount, streamDone);
        end
        // Still idle a few cycles later: nothing restarts without start.
        bus.inValid = 1'b1; bus.done = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.work !== 1'b0 || bus.inReady !== 1'b0 || pairCount !== 32'd0) begin
            failures++;
            $display("FAIL rstmid idle: got w=%b rdy=%b cnt=%0d want 0 0 0",
                     bus.work, bus.inReady, pairCount);
        end
        bus.inValid = 1'b0; bus.done = 1'b0;
        run_stream('{8'hD1, 8'h58, 8'h1F}, -1, 0, 1'b0, 0, 0, "rstmid2");
        check_ordered("rstmid2");
    endtask

    task automatic test_start_in_run();
        run_stream('{8'hD1, 8'h58, 8'h1F}, -1, 0, 1'b0, 3, 0, "startrun");
        check_ordered("startrun");
    endtask

    initial begin
        test_reset();
        test_ordered();
        test_stall();
        test_discard();
        test_overlap();
        test_random();
        test_reset_mid();
        test_start_in_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
